// File: rtl/rr_req_agent.sv
// rr_req_agent: requester-side agent for one port of a 2-way round-robin arbiter.
// Local transactions are queued in a DEPTH-entry FIFO. req is raised while
// entries are pending. On gnt the head entry is presented on out_* for that
// cycle and popped.
// Optional feature macro: RR_REQ_STARVE_EN enables the ungranted-wait counter
// and the starve flag. When the macro is undefined, starve is tied low.
module rr_req_agent #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       req,
    input  logic                       gnt,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       gnt_err,
    output logic                       starve
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [AW-1:0]                rd_ptr;
    logic [AW-1:0]                wr_ptr;
    logic                         push;
    logic                         pop;

    // Status decode. A transfer is masked while in reset, so the reset cycle
    // never moves data even if the arbiter grants.
    assign in_ready  = (count != CW'(DEPTH));
    assign req       = (count != '0);
    assign out_valid = rst_n && req && gnt;
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid;

    // Payload storage. It needs no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and the sticky grant-error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            gnt_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (gnt && !req) gnt_err <= 1'b1;
        end
    end

`ifdef RR_REQ_STARVE_EN
    logic [7:0] wait_cnt;

    // Count consecutive ungranted request cycles, saturating at 255.
    always_ff @(posedge clk) begin
        if (!rst_n || gnt || !req) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign starve = (wait_cnt >= 8'(STARVE_MAX));
`else
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX != 0);
    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_rr_req_agent.sv
// Self-checking bench for rr_req_agent. A queue-based model predicts every
// output on every cycle. Directed steps add literal expectations that pin
// the model to the hand-computed values.
module tb_rr_req_agent;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
`ifdef RR_REQ_STARVE_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              req;
    logic              gnt = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        count;
    logic              gnt_err;
    logic              starve;

    int checks = 0;
    int failures = 0;

    rr_req_agent #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .req(req), .gnt(gnt), .out_valid(out_valid),
        .out_data(out_data), .count(count), .gnt_err(gnt_err), .starve(starve)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] mq[$];
    bit                m_err = 1'b0;
    int                m_wait = 0;
    bit                armed = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_err  = 1'b0;
            m_wait = 0;
            armed  = 1'b1;
        end else begin
            int  n;
            bit  do_pop, do_push;
            n       = mq.size();
            do_pop  = (n > 0) && gnt;
            do_push = in_valid && (n < DEPTH);
            if (gnt && n == 0) m_err = 1'b1;
            if (gnt || n == 0) m_wait = 0;
            else if (m_wait < 255) m_wait++;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(in_data);
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: inputs change at negedge, so outputs are checked 2 time units later.
    always @(negedge clk) begin
        #2;
        if (armed) begin
            bit e_ov;
            e_ov = rst_n && (mq.size() > 0) && gnt;
            cmp("m_in_ready", int'(in_ready), int'(mq.size() < DEPTH));
            cmp("m_req",      int'(req),      int'(mq.size() != 0));
            cmp("m_count",    int'(count),    mq.size());
            cmp("m_out_valid", int'(out_valid), int'(e_ov));
            if (e_ov) cmp("m_out_data", int'(out_data), int'(mq[0]));
            cmp("m_gnt_err",  int'(gnt_err),  int'(m_err));
            cmp("m_starve",   int'(starve),   int'(SEN && m_wait >= 15));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic g);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        gnt      = g;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        // Reset, then idle
        rst_n = 1'b0;
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0); rst_n = 1'b1; settle();
        cmp("rst_req", int'(req), 0);
        cmp("rst_in_ready", int'(in_ready), 1);
        cmp("rst_count", int'(count), 0);
        cmp("rst_out_valid", int'(out_valid), 0);
        cmp("rst_gnt_err", int'(gnt_err), 0);

        // Three pushes, then three grants
        drive(1, 8'hA1, 0); settle(); cmp("push_cycle_req", int'(req), 0);
        drive(1, 8'hB2, 0); settle(); cmp("req_after_push", int'(req), 1);
        drive(1, 8'hC3, 0);
        drive(0, 8'h00, 0); settle(); cmp("count3", int'(count), 3);
        drive(0, 8'h00, 1); settle(); cmp("pop_a1", int'(out_data), 'hA1); cmp("ov_a1", int'(out_valid), 1);
        drive(0, 8'h00, 1); settle(); cmp("pop_b2", int'(out_data), 'hB2);
        drive(0, 8'h00, 1); settle(); cmp("pop_c3", int'(out_data), 'hC3);
        drive(0, 8'h00, 0); settle(); cmp("drained_req", int'(req), 0); cmp("drained_count", int'(count), 0);

        // Fill, drop when full, and accept again after a pop
        drive(1, 8'h11, 0);
        drive(1, 8'h22, 0);
        drive(1, 8'h33, 0);
        drive(1, 8'h44, 0);
        drive(1, 8'hEE, 0); settle(); cmp("full_ready", int'(in_ready), 0); cmp("full_count", int'(count), 4);
        drive(0, 8'h00, 1); settle(); cmp("full_pop", int'(out_data), 'h11); cmp("full_pop_ready", int'(in_ready), 0);
        drive(1, 8'hEE, 0); settle(); cmp("ready_after_pop", int'(in_ready), 1); cmp("count_after_pop", int'(count), 3);
        drive(0, 8'h00, 1); settle(); cmp("order_22", int'(out_data), 'h22);
        drive(0, 8'h00, 1); settle(); cmp("order_33", int'(out_data), 'h33);
        drive(0, 8'h00, 1); settle(); cmp("order_44", int'(out_data), 'h44);
        drive(0, 8'h00, 1); settle(); cmp("order_ee", int'(out_data), 'hEE);
        drive(0, 8'h00, 0); settle(); cmp("fill_drained", int'(count), 0);

        // Concurrent push and pop at count=2 across pointer wrap
        drive(1, 8'h51, 0);
        drive(1, 8'h52, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'(8'h53 + i), 1); settle();
            cmp("conc_count", int'(count), 2);
            cmp("conc_data", int'(out_data), 'h51 + i);
        end
        drive(0, 8'h00, 1); settle(); cmp("conc_tail57", int'(out_data), 'h57);
        drive(0, 8'h00, 1); settle(); cmp("conc_tail58", int'(out_data), 'h58);

        // Grant while empty sets a sticky error
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 1); settle(); cmp("empty_gnt_ov", int'(out_valid), 0); cmp("empty_gnt_count", int'(count), 0);
        drive(0, 8'h00, 0); settle(); cmp("gnt_err_set", int'(gnt_err), 1);
        drive(1, 8'h61, 0);
        drive(1, 8'h62, 0);
        drive(0, 8'h00, 0); settle(); cmp("gnt_err_sticky", int'(gnt_err), 1); cmp("pre_rst_count", int'(count), 2);
        drive(0, 8'h00, 0); rst_n = 1'b0;
        drive(0, 8'h00, 0); rst_n = 1'b1; settle();
        cmp("gnt_err_cleared", int'(gnt_err), 0); cmp("midrst_count", int'(count), 0); cmp("midrst_req", int'(req), 0);

        // Starvation: two entries waiting, no grant
        drive(1, 8'h77, 0);
        drive(1, 8'h78, 0);
        for (int k = 2; k <= 21; k++) begin
            drive(0, 8'h00, 0); settle();
            cmp("starve_seq", int'(starve), int'(SEN && k >= 16));
        end
        drive(0, 8'h00, 1); settle(); cmp("starve_gnt_data", int'(out_data), 'h77);
        drive(0, 8'h00, 0); settle(); cmp("starve_cleared", int'(starve), 0); cmp("starve_req_held", int'(req), 1);
        drive(0, 8'h00, 1);
        drive(0, 8'h00, 0); settle(); cmp("final_count", int'(count), 0);
        drive(0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
